mdu_unit: RTL and testbench

- Multiply/divide unit beside the ALU in the MIPS datapath.
- Consumes GRF operands (rs, rt) and owns the architectural HI/LO registers.
- Models the MULT/MULTU/DIV/DIVU latency with a busy counter, so the downstream pipeline controller can stall on busy.
- MFHI/MFLO read the hi/lo outputs combinationally from the registers.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_arith.sv | 82 ++++++++
 rtl/mdu_unit.sv | 141 ++++++++++++++
 tb/tb_mdu_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_pkg                                                  |
// | Brief   : Shared op encodings, latency defaults and FSM state type |
// |           for the multiply/divide unit.                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;
    localparam logic [2:0] MDU_MADDU = 3'd7;

    localparam int MDU_MULT_LAT_DEF = 5;
    localparam int MDU_DIV_LAT_DEF  = 10;

    // Counter must hold the larger latency as a load value.
    function automatic int mdu_cnt_width(input int mult_lat, input int div_lat);
        int max_lat;
        max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(max_lat + 1);
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_width(MDU_MULT_LAT_DEF, MDU_DIV_LAT_DEF);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_arith                                                |
// | Brief   : Combinational 64-bit result generator for MULT/DIV ops.  |
// |           MADD/MADDU accumulate only when MDU_MADD_EN is defined.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo,
    output logic        div0
);

    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic               w_b_zero;
    logic               w_sdiv_ovf;
    logic        [31:0] w_sdivisor;
    logic        [31:0] w_udivisor;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquot;
    logic        [31:0] w_urem;

    assign w_a_sx  = {{32{a[31]}}, a};
    assign w_b_sx  = {{32{b[31]}}, b};
    assign w_sprod = w_a_sx * w_b_sx;
    assign w_uprod = {32'd0, a} * {32'd0, b};

    // Dividing by 1 in the overflow case yields exactly 0x80000000 rem 0.
    assign w_b_zero   = (b == 32'd0);
    assign w_sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_sdivisor = (w_b_zero || w_sdiv_ovf) ? 32'd1 : b;
    assign w_udivisor = w_b_zero ? 32'd1 : b;

    assign w_squot = $signed(a) / $signed(w_sdivisor);
    assign w_srem  = $signed(a) % $signed(w_sdivisor);
    assign w_uquot = a / w_udivisor;
    assign w_urem  = a % w_udivisor;

    always_comb begin
        pend_hi = hi;
        pend_lo = lo;
        div0    = 1'b0;
        case (op)
            MDU_MULT:  {pend_hi, pend_lo} = w_sprod;
            MDU_MULTU: {pend_hi, pend_lo} = w_uprod;
            MDU_DIV: begin
                if (w_b_zero) begin
                    div0 = 1'b1;
                end else begin
                    pend_lo = w_squot;
                    pend_hi = w_srem;
                end
            end
            MDU_DIVU: begin
                if (w_b_zero) begin
                    div0 = 1'b1;
                end else begin
                    pend_lo = w_uquot;
                    pend_hi = w_urem;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {pend_hi, pend_lo} = {hi, lo} + w_sprod;
            MDU_MADDU: {pend_hi, pend_lo} = {hi, lo} + w_uprod;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_unit                                                 |
// | Brief   : MIPS multiply/divide unit: HI/LO registers, issue FSM    |
// |           and latency counter. Macro MDU_MADD_EN enables MADD(U).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int                 c_cnt_w    = mdu_cnt_width(MULT_LAT, DIV_LAT);
    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_LAT);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_LAT);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_div0;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_div0;
    logic               w_is_long;
    logic               w_is_div;
    logic               w_launch;
    logic               w_commit;
    logic               w_mthi;
    logic               w_mtlo;

    mdu_arith u_arith (
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (r_hi),
        .lo      (r_lo),
        .pend_hi (w_res_hi),
        .pend_lo (w_res_lo),
        .div0    (w_div0)
    );

    assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
    assign w_is_long = (op == MDU_MULT) || (op == MDU_MULTU) || w_is_div ||
                       (op == MDU_MADD) || (op == MDU_MADDU);
`else
    assign w_is_long = (op == MDU_MULT) || (op == MDU_MULTU) || w_is_div;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_launch     = 1'b0;
        w_commit     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_long) begin
                        w_launch     = 1'b1;
                        w_state_next = ST_RUN;
                        w_cnt_next   = w_is_div ? c_div_cnt : c_mult_cnt;
                    end else if (op == MDU_MTHI) begin
                        w_mthi = 1'b1;
                    end else if (op == MDU_MTLO) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Any start seen here is dropped; the pipeline must stall on busy.
                if (r_cnt == c_cnt_one) begin
                    w_commit     = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_launch) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_div0    <= w_div0;
            end
            if (w_commit && !r_div0) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    assign busy = (r_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_mdu_unit                                              |
// | Brief   : Table-driven scoreboard bench for mdu_unit (MULT_LAT=5,  |
// |           DIV_LAT=10); MADD rows follow MDU_MADD_EN.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int NV        = 17;
    localparam int IDLE_WAIT = 200;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];

    mdu_unit #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] e_hi, input logic [31:0] e_lo, input int cyc);
        exp_t e;
        e.hi     = e_hi;
        e.lo     = e_lo;
        e.cycles = cyc;
        sb_q.push_back(e);
    endtask

    // Counts busy cycles from the current negedge until busy is low.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < IDLE_WAIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= IDLE_WAIT) begin
            tests_run++;
            tests_failed++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected release", n);
        end
    endtask

    task automatic sb_check(input string tag, input int cycles);
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_sb_empty: got no expected entry, expected one", tag);
        end else begin
            e = sb_q.pop_front();
            check_int({tag, "_busy"}, cycles, e.cycles);
            check32({tag, "_hi"}, hi, e.hi);
            check32({tag, "_lo"}, lo, e.lo);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int busy_seen;

        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{MDU_MTHI,  32'h0000_0011, 32'd0,        32'h0000_0011, 32'hFFFF_FFFD, 0};
        vecs[4]  = '{MDU_MTLO,  32'h0000_0022, 32'd0,        32'h0000_0011, 32'h0000_0022, 0};
        vecs[5]  = '{MDU_DIVU,  32'd7,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
        vecs[6]  = '{MDU_MTHI,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'h0000_0022, 0};
        vecs[7]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[8]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 10};
        vecs[9]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[10] = '{MDU_DIV,   32'd5,         32'd0,        32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[11] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[12] = '{MDU_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5};
        vecs[13] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
`ifdef MDU_MADD_EN
        vecs[14] = '{MDU_MADD,  32'd2,         32'd3,        32'hFFFF_FFFE, 32'h0000_0007, 5};
        vecs[15] = '{MDU_MADDU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0000, 32'h0000_0005, 5};
        vecs[16] = '{MDU_MADD,  32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0003, 5};
`else
        vecs[14] = '{MDU_MADD,  32'd2,         32'd3,        32'hFFFF_FFFE, 32'h0000_0001, 0};
        vecs[15] = '{MDU_MADDU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 32'h0000_0001, 0};
        vecs[16] = '{MDU_MADD,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
`endif

        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b1;
        #2;
        check_int("reset_busy", int'(busy), 0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            sb_push(vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_busy);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            sb_check($sformatf("vec%0d", i), n);
        end

        // MTLO and a second MULT during busy must both be dropped.
        sb_push(32'h0, 32'hF, 5);
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd5;
        @(negedge clk);
        op = MDU_MTLO; a = 32'h55;
        @(negedge clk);
        op = MDU_MULT; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        sb_check("mtlo_in_mult", n + 2);

        // A divide by zero keeps hi/lo, so a dropped MTLO stays visible.
        sb_push(32'h0, 32'hF, 10);
        @(negedge clk);
        start = 1'b1; op = MDU_DIVU; a = 32'd7; b = 32'd0;
        @(negedge clk);
        op = MDU_MTLO; a = 32'h55;
        @(negedge clk);
        op = MDU_MTHI; a = 32'h66;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        sb_check("mt_in_div0", n + 2);

        // Back-to-back issue on the first idle cycle.
        sb_push(32'h0, 32'h6, 5);
        drive(MDU_MULT, 32'd2, 32'd3);
        wait_idle(n);
        sb_check("b2b_mult", n);
        sb_push(32'h1, 32'h2, 10);
        start = 1'b1; op = MDU_DIV; a = 32'd9; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        sb_check("b2b_div", n);

        // Reset in the fourth busy cycle of a DIV aborts without commit.
        drive(MDU_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check_int("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_int("async_reset_busy", int'(busy), 0);
        check32("async_reset_hi", hi, 32'd0);
        check32("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        check_int("post_reset_busy_cycles", busy_seen, 0);
        check32("post_reset_hi", hi, 32'd0);
        check32("post_reset_lo", lo, 32'd0);
        check_int("sb_left", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
